neuron_cmd_master: RTL and testbench

Bus master for the neuron configuration/run bus (`addr`, `cmd`, `cmd_arg`) shared by all spiking neurons. It accepts configuration writes from the host through a valid/ready port and buffers them in a small FIFO. It sequences them onto the bus and also owns simulation time: it drives the bus-wide "tick" (`cmd == 0`) for a programmed number of cycles. Otherwise it parks the bus on a no-op so neuron state stays frozen.

---
 rtl/neuron_cmd_master_if.sv | 27 ++
 rtl/neuron_cmd_master.sv | 150 +++++++++++++++
 tb/tb_neuron_cmd_master.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_cmd_master_if.sv
// Host request port and neuron bus of the neuron command master.
// Handshake: a request transfers on a rising clk edge when req_valid && req_ready; req_ready never depends on req_valid.
interface neuron_cmd_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int CMD_WIDTH  = 8,
    parameter int INT_WIDTH  = 8
);
    logic                   req_valid;
    logic                   req_ready;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [CMD_WIDTH-1:0]   req_cmd;
    logic [2*INT_WIDTH-1:0] req_arg;

    logic [ADDR_WIDTH-1:0]  addr;
    logic [CMD_WIDTH-1:0]   cmd;
    logic [2*INT_WIDTH-1:0] cmd_arg;

    modport master (
        input  req_valid, req_addr, req_cmd, req_arg,
        output req_ready, addr, cmd, cmd_arg
    );

    modport slave (
        output req_valid, req_addr, req_cmd, req_arg,
        input  req_ready, addr, cmd, cmd_arg
    );
endinterface

// File: rtl/neuron_cmd_master.sv
// Neuron bus master: buffers host config writes in a FIFO, drives run ticks,
// and parks the bus on a no-op otherwise. Config writes take priority over ticks.
module neuron_cmd_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int CMD_WIDTH  = 8,
    parameter int INT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_ADDR  = (1 << ADDR_WIDTH) - 1,
    parameter int HOLD_CMD   = 3,
    parameter int TICK_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    neuron_cmd_master_if.master          bus,
    input  logic                         run_start,
    input  logic [TICK_WIDTH-1:0]        run_ticks,
    output logic                         run_busy,
    output logic                         run_done,
    output logic [TICK_WIDTH-1:0]        ticks_left,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         err_zero_cmd,
    output logic                         state_dbg
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ARG_W   = 2 * INT_WIDTH;
    localparam int ENTRY_W = ADDR_WIDTH + CMD_WIDTH + ARG_W;

    localparam logic [ADDR_WIDTH-1:0] HOLD_ADDR_V = ADDR_WIDTH'(HOLD_ADDR);
    localparam logic [CMD_WIDTH-1:0]  HOLD_CMD_V  = CMD_WIDTH'(HOLD_CMD);
    localparam logic [LVL_W-1:0]      DEPTH_V     = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]      LVL_ONE     = LVL_W'(1);
    localparam logic [PTR_W-1:0]      PTR_ONE     = PTR_W'(1);
    localparam logic [TICK_WIDTH-1:0] TICK_ONE    = TICK_WIDTH'(1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [TICK_WIDTH-1:0]   ticks_q, ticks_d;
    logic                    done_q, done_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic                    err_q;
    logic [ENTRY_W-1:0]      mem [FIFO_DEPTH];

    logic                    ready;
    logic                    accept;
    logic                    enq;
    logic                    pop;
    logic [ENTRY_W-1:0]      head;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [CMD_WIDTH-1:0]    cmd_d;
    logic [ARG_W-1:0]        arg_d;

    // Ready comes only from the registered level, so a pop cannot reopen a full FIFO in the same cycle.
    assign ready  = (level_q != DEPTH_V);
    assign accept = bus.req_valid && ready;
    assign enq    = accept && (bus.req_cmd != '0);
    assign pop    = (level_q != '0);
    assign head   = mem[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        ticks_d = ticks_q;
        done_d  = 1'b0;
        addr_d  = HOLD_ADDR_V;
        cmd_d   = HOLD_CMD_V;
        arg_d   = '0;

        if (pop) begin
            addr_d = head[ENTRY_W-1 -: ADDR_WIDTH];
            cmd_d  = head[ARG_W +: CMD_WIDTH];
            arg_d  = head[ARG_W-1:0];
        end else if (state_q == RUN) begin
            addr_d  = '0;
            cmd_d   = '0;
            ticks_d = ticks_q - TICK_ONE;
            if (ticks_q == TICK_ONE) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        // In RUN a new start request is ignored; a zero-length run only pulses done.
        if (state_q == IDLE && run_start) begin
            if (run_ticks != '0) begin
                state_d = RUN;
                ticks_d = run_ticks;
            end else begin
                done_d = 1'b1;
            end
        end
    end

    always_comb begin
        level_d = level_q;
        case ({enq, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ticks_q     <= '0;
            done_q      <= 1'b0;
            level_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
            bus.addr    <= HOLD_ADDR_V;
            bus.cmd     <= HOLD_CMD_V;
            bus.cmd_arg <= '0;
        end else begin
            state_q     <= state_d;
            ticks_q     <= ticks_d;
            done_q      <= done_d;
            level_q     <= level_d;
            bus.addr    <= addr_d;
            bus.cmd     <= cmd_d;
            bus.cmd_arg <= arg_d;
            if (enq) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (accept && (bus.req_cmd == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr_q] <= {bus.req_addr, bus.req_cmd, bus.req_arg};
        end
    end

    assign bus.req_ready  = ready;
    assign run_busy       = (state_q == RUN);
    assign run_done       = done_q;
    assign ticks_left     = ticks_q;
    assign fifo_level     = level_q;
    assign err_zero_cmd   = err_q;
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_neuron_cmd_master.sv
// Self-checking bench for neuron_cmd_master: vector table, directed corner sequences,
// and random traffic checked against a queue-based model of the bus rules.
module tb_neuron_cmd_master;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        run_start;
    logic [15:0] run_ticks;
    logic        run_busy;
    logic        run_done;
    logic [15:0] ticks_left;
    logic [2:0]  fifo_level;
    logic        err_zero_cmd;
    logic        state_dbg;

    neuron_cmd_master_if #(.ADDR_WIDTH(8), .CMD_WIDTH(8), .INT_WIDTH(8)) bus_if ();

    neuron_cmd_master #(
        .ADDR_WIDTH(8), .CMD_WIDTH(8), .INT_WIDTH(8), .FIFO_DEPTH(DEPTH),
        .HOLD_ADDR(255), .HOLD_CMD(3), .TICK_WIDTH(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_if),
        .run_start    (run_start),
        .run_ticks    (run_ticks),
        .run_busy     (run_busy),
        .run_done     (run_done),
        .ticks_left   (ticks_left),
        .fifo_level   (fifo_level),
        .err_zero_cmd (err_zero_cmd),
        .state_dbg    (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pending requests, remaining ticks, and the expected bus word.
    logic [31:0] exp_q[$];
    int          m_ticks;
    bit          m_done;
    bit          m_err;
    logic [7:0]  m_addr;
    logic [7:0]  m_cmd;
    logic [15:0] m_arg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ticks = 0;
        m_done  = 0;
        m_err   = 0;
        m_addr  = 8'd255;
        m_cmd   = 8'd3;
        m_arg   = 16'd0;
    endtask

    task automatic model_edge();
        bit ready;
        bit was_busy;
        logic [31:0] head;
        ready    = (exp_q.size() != DEPTH);
        was_busy = (m_ticks > 0);
        m_done   = 0;
        if (exp_q.size() > 0) begin
            head = exp_q.pop_front();
            m_addr = head[31:24];
            m_cmd  = head[23:16];
            m_arg  = head[15:0];
        end else if (m_ticks > 0) begin
            m_addr = 8'd0;
            m_cmd  = 8'd0;
            m_arg  = 16'd0;
            m_ticks--;
            if (m_ticks == 0) m_done = 1;
        end else begin
            m_addr = 8'd255;
            m_cmd  = 8'd3;
            m_arg  = 16'd0;
        end
        if (!was_busy && run_start) begin
            if (run_ticks != 0) m_ticks = int'(run_ticks);
            else m_done = 1;
        end
        if (bus_if.req_valid && ready) begin
            if (bus_if.req_cmd == 8'd0) m_err = 1;
            else exp_q.push_back({bus_if.req_addr, bus_if.req_cmd, bus_if.req_arg});
        end
    endtask

    task automatic check_model();
        chk("addr",       32'(bus_if.addr),      32'(m_addr));
        chk("cmd",        32'(bus_if.cmd),       32'(m_cmd));
        chk("cmd_arg",    32'(bus_if.cmd_arg),   32'(m_arg));
        chk("req_ready",  32'(bus_if.req_ready), 32'(exp_q.size() != DEPTH));
        chk("fifo_level", 32'(fifo_level),       32'(exp_q.size()));
        chk("run_busy",   32'(run_busy),         32'(m_ticks > 0));
        chk("run_done",   32'(run_done),         32'(m_done));
        chk("ticks_left", 32'(ticks_left),       32'(m_ticks));
        chk("err_zero",   32'(err_zero_cmd),     32'(m_err));
    endtask

    task automatic idle_inputs();
        bus_if.req_valid = 1'b0;
        bus_if.req_addr  = 8'd0;
        bus_if.req_cmd   = 8'd0;
        bus_if.req_arg   = 16'd0;
        run_start        = 1'b0;
        run_ticks        = 16'd0;
    endtask

    task automatic push_in(input logic [7:0] a, input logic [7:0] c, input logic [15:0] g);
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = a;
        bus_if.req_cmd   = c;
        bus_if.req_arg   = g;
    endtask

    // Inputs are set 1 time unit after an edge; outputs are sampled 1 unit after the next edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_addr",  32'(bus_if.addr),      32'd255);
        chk("rst_cmd",   32'(bus_if.cmd),       32'd3);
        chk("rst_arg",   32'(bus_if.cmd_arg),   32'd0);
        chk("rst_ready", 32'(bus_if.req_ready), 32'd1);
        chk("rst_level", 32'(fifo_level),       32'd0);
        chk("rst_busy",  32'(run_busy),         32'd0);
        chk("rst_done",  32'(run_done),         32'd0);
        chk("rst_ticks", 32'(ticks_left),       32'd0);
        chk("rst_err",   32'(err_zero_cmd),     32'd0);
        @(posedge clk);
        #1;
        check_model();
        rst = 1'b1;
    endtask

    typedef struct {
        bit          valid;
        logic [7:0]  a;
        logic [7:0]  c;
        logic [15:0] g;
        bit          start;
        logic [15:0] n;
        logic [7:0]  e_addr;
        logic [7:0]  e_cmd;
        logic [15:0] e_arg;
        bit          e_busy;
        bit          e_done;
        logic [15:0] e_ticks;
    } vec_t;

    vec_t vt[15];

    initial begin
        int ticks_seen;
        int writes_seen;
        int done_at;
        logic [7:0] a;
        logic [7:0] c;

        rst = 1'b1;
        idle_inputs();
        model_reset();
        #2;
        apply_reset();

        vt[0]  = '{1, 8'd5, 8'd1, 16'h0040, 0, 16'd0, 8'd255, 8'd3, 16'h0000, 0, 0, 16'd0};
        vt[1]  = '{0, 8'd0, 8'd0, 16'h0000, 0, 16'd0, 8'd5,   8'd1, 16'h0040, 0, 0, 16'd0};
        vt[2]  = '{0, 8'd0, 8'd0, 16'h0000, 0, 16'd0, 8'd255, 8'd3, 16'h0000, 0, 0, 16'd0};
        vt[3]  = '{0, 8'd0, 8'd0, 16'h0000, 1, 16'd3, 8'd255, 8'd3, 16'h0000, 1, 0, 16'd3};
        vt[4]  = '{0, 8'd0, 8'd0, 16'h0000, 0, 16'd0, 8'd0,   8'd0, 16'h0000, 1, 0, 16'd2};
        vt[5]  = '{0, 8'd0, 8'd0, 16'h0000, 0, 16'd0, 8'd0,   8'd0, 16'h0000, 1, 0, 16'd1};
        vt[6]  = '{0, 8'd0, 8'd0, 16'h0000, 0, 16'd0, 8'd0,   8'd0, 16'h0000, 0, 1, 16'd0};
        vt[7]  = '{0, 8'd0, 8'd0, 16'h0000, 0, 16'd0, 8'd255, 8'd3, 16'h0000, 0, 0, 16'd0};
        vt[8]  = '{0, 8'd0, 8'd0, 16'h0000, 1, 16'd0, 8'd255, 8'd3, 16'h0000, 0, 1, 16'd0};
        vt[9]  = '{0, 8'd0, 8'd0, 16'h0000, 0, 16'd0, 8'd255, 8'd3, 16'h0000, 0, 0, 16'd0};
        vt[10] = '{1, 8'd7, 8'd2, 16'h1234, 1, 16'd2, 8'd255, 8'd3, 16'h0000, 1, 0, 16'd2};
        vt[11] = '{0, 8'd0, 8'd0, 16'h0000, 0, 16'd0, 8'd7,   8'd2, 16'h1234, 1, 0, 16'd2};
        vt[12] = '{0, 8'd0, 8'd0, 16'h0000, 0, 16'd0, 8'd0,   8'd0, 16'h0000, 1, 0, 16'd1};
        vt[13] = '{0, 8'd0, 8'd0, 16'h0000, 0, 16'd0, 8'd0,   8'd0, 16'h0000, 0, 1, 16'd0};
        vt[14] = '{0, 8'd0, 8'd0, 16'h0000, 0, 16'd0, 8'd255, 8'd3, 16'h0000, 0, 0, 16'd0};

        for (int i = 0; i < 15; i++) begin
            bus_if.req_valid = vt[i].valid;
            bus_if.req_addr  = vt[i].a;
            bus_if.req_cmd   = vt[i].c;
            bus_if.req_arg   = vt[i].g;
            run_start        = vt[i].start;
            run_ticks        = vt[i].n;
            step();
            chk($sformatf("vec%0d_addr", i),  32'(bus_if.addr),    32'(vt[i].e_addr));
            chk($sformatf("vec%0d_cmd", i),   32'(bus_if.cmd),     32'(vt[i].e_cmd));
            chk($sformatf("vec%0d_arg", i),   32'(bus_if.cmd_arg), 32'(vt[i].e_arg));
            chk($sformatf("vec%0d_busy", i),  32'(run_busy),       32'(vt[i].e_busy));
            chk($sformatf("vec%0d_done", i),  32'(run_done),       32'(vt[i].e_done));
            chk($sformatf("vec%0d_ticks", i), 32'(ticks_left),     32'(vt[i].e_ticks));
        end
        idle_inputs();

        // Back-to-back burst of 10 wraps the pointers; each request appears one edge after its push.
        for (int i = 0; i < 11; i++) begin
            if (i < 10) push_in(8'(20 + i), 8'd2, 16'(16'hA000 + i));
            else idle_inputs();
            step();
            if (i > 0) begin
                chk($sformatf("wrap%0d_addr", i), 32'(bus_if.addr), 32'(20 + i - 1));
                chk($sformatf("wrap%0d_arg", i),  32'(bus_if.cmd_arg), 32'(16'hA000 + i - 1));
            end
        end
        idle_inputs();
        step();

        // Five-tick run with two writes interleaved and an ignored second start.
        run_start = 1'b1;
        run_ticks = 16'd5;
        step();
        idle_inputs();
        ticks_seen  = 0;
        writes_seen = 0;
        done_at     = -1;
        for (int c2 = 1; c2 <= 12; c2++) begin
            idle_inputs();
            if (c2 == 2 || c2 == 3) push_in(8'(40 + c2), 8'd1, 16'h00FF);
            if (c2 == 4) begin
                run_start = 1'b1;
                run_ticks = 16'd9;
            end
            step();
            if (bus_if.cmd == 8'd0 && bus_if.addr == 8'd0) ticks_seen++;
            if (bus_if.cmd == 8'd1) writes_seen++;
            if (run_done) done_at = c2;
        end
        idle_inputs();
        chk("ilv_ticks",   32'(ticks_seen),  32'd5);
        chk("ilv_writes",  32'(writes_seen), 32'd2);
        chk("ilv_done_at", 32'(done_at),     32'd7);

        // A zero command is swallowed and flagged.
        push_in(8'd9, 8'd0, 16'h5555);
        step();
        idle_inputs();
        chk("zero_err",   32'(err_zero_cmd), 32'd1);
        chk("zero_level", 32'(fifo_level),   32'd0);
        step();
        chk("zero_bus",   32'(bus_if.cmd),   32'd3);

        // Reset in the middle of a long run: no done pulse afterwards, error flag cleared.
        run_start = 1'b1;
        run_ticks = 16'd20;
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) step();
        apply_reset();
        done_at = -1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (run_done) done_at = i;
        end
        chk("abort_no_done", 32'(done_at), 32'hFFFF_FFFF);

        // Random traffic against the model, with one reset partway through.
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            if ($urandom_range(0, 3) != 0) begin
                a = 8'($urandom_range(0, 254));
                c = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                push_in(a, c, 16'($urandom));
            end
            if ($urandom_range(0, 19) == 0) begin
                run_start = 1'b1;
                run_ticks = 16'($urandom_range(0, 6));
            end
            if (i == 200) begin
                apply_reset();
            end else begin
                step();
            end
        end
        idle_inputs();
        for (int i = 0; i < 10; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
